// File: rtl/sr_latch.sv
// Gated SR latch bank with async reset, selectable S=R=1 policy and a sticky error flag.
// Optional SR_LATCH_ERR_CNT_EN adds err_cnt, a saturating count of falling edges that saw S=R=1.
module sr_latch #(
    parameter int               WIDTH          = 1,
    parameter logic [WIDTH-1:0] RESET_Q        = '0,
    parameter int               INVALID_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] invalid,
    output logic             err_sticky
`ifdef SR_LATCH_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] setMask;
    logic [WIDTH-1:0] clrMask;
    logic [WIDTH-1:0] bothHigh;
    logic             errSticky_q;

    // Resolve each bit's request up front so the latch only ever writes constants
    always_comb begin
        bothHigh = s & r;
        setMask  = s & ~r;
        clrMask  = r & ~s;
        if (INVALID_POLICY == 1) begin
            clrMask = clrMask | bothHigh;
        end else if (INVALID_POLICY == 2) begin
            setMask = setMask | bothHigh;
        end
    end

    always_latch begin
        if (rst) begin
            q_q <= RESET_Q;
        end else if (clk) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (setMask[i]) begin
                    q_q[i] <= 1'b1;
                end else if (clrMask[i]) begin
                    q_q[i] <= 1'b0;
                end
            end
        end
    end

    assign invalid = {WIDTH{clk}} & s & r;

    // Sticky flag is itself a latch: opened by any invalid bit, cleared only by reset
    always_latch begin
        if (rst) begin
            errSticky_q <= 1'b0;
        end else if (|invalid) begin
            errSticky_q <= 1'b1;
        end
    end

    assign q          = q_q;
    assign qbar       = ~q_q;
    assign err_sticky = errSticky_q;

`ifdef SR_LATCH_ERR_CNT_EN
    logic [7:0] errCnt_q;
    logic [7:0] errCnt_d;

    always_comb begin
        errCnt_d = errCnt_q;
        if ((|bothHigh) && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    // Counted on the closing edge so each open phase ending in S=R=1 counts once
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_sr_latch.sv
// Bench for sr_latch: three 1-bit instances (one per invalid policy) and one 4-bit instance,
// checked against a rule-level model; err_cnt is covered when SR_LATCH_ERR_CNT_EN is defined.
module tb_sr_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1  = 1'b0;
    logic       r1  = 1'b0;
    logic [3:0] s4  = 4'd0;
    logic [3:0] r4  = 4'd0;

    logic qA, qbA, invA, errA;
    logic qB, qbB, invB, errB;
    logic qC, qbC, invC, errC;
    logic [3:0] qD, qbD, invD;
    logic errD;
`ifdef SR_LATCH_ERR_CNT_EN
    logic [7:0] cntA, cntB, cntC, cntD;
`endif

    int nCmp  = 0;
    int nFail = 0;

    // Model state, index 0..2 = 1-bit policies 0/1/2, index 3 = 4-bit instance
    logic [3:0] mq [4];
    logic       me [4];
    int         mc [4];
    int         pol [4]  = '{0, 1, 2, 0};
    int         wid [4]  = '{1, 1, 1, 4};
    logic [3:0] rstv [4] = '{4'd0, 4'd0, 4'd0, 4'b1010};

    sr_latch #(.WIDTH(1), .RESET_Q(1'b0), .INVALID_POLICY(0)) dutA (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(qA), .qbar(qbA), .invalid(invA), .err_sticky(errA)
`ifdef SR_LATCH_ERR_CNT_EN
        , .err_cnt(cntA)
`endif
    );
    sr_latch #(.WIDTH(1), .RESET_Q(1'b0), .INVALID_POLICY(1)) dutB (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(qB), .qbar(qbB), .invalid(invB), .err_sticky(errB)
`ifdef SR_LATCH_ERR_CNT_EN
        , .err_cnt(cntB)
`endif
    );
    sr_latch #(.WIDTH(1), .RESET_Q(1'b0), .INVALID_POLICY(2)) dutC (
        .clk(clk), .rst(rst), .s(s1), .r(r1), .q(qC), .qbar(qbC), .invalid(invC), .err_sticky(errC)
`ifdef SR_LATCH_ERR_CNT_EN
        , .err_cnt(cntC)
`endif
    );
    sr_latch #(.WIDTH(4), .RESET_Q(4'b1010), .INVALID_POLICY(0)) dutD (
        .clk(clk), .rst(rst), .s(s4), .r(r4), .q(qD), .qbar(qbD), .invalid(invD), .err_sticky(errD)
`ifdef SR_LATCH_ERR_CNT_EN
        , .err_cnt(cntD)
`endif
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] inS(int k);
        return (k == 3) ? s4 : {3'b000, s1};
    endfunction

    function automatic logic [3:0] inR(int k);
        return (k == 3) ? r4 : {3'b000, r1};
    endfunction

    function automatic logic [3:0] widthMask(int k);
        return (wid[k] == 4) ? 4'hF : 4'h1;
    endfunction

    // Latch rule table applied bit by bit
    function automatic logic [3:0] rule(logic [3:0] cur, logic [3:0] sv, logic [3:0] rv, int p, int w);
        logic [3:0] nxt;
        nxt = cur;
        for (int i = 0; i < w; i++) begin
            if (sv[i] && !rv[i]) nxt[i] = 1'b1;
            else if (!sv[i] && rv[i]) nxt[i] = 1'b0;
            else if (sv[i] && rv[i]) begin
                if (p == 1) nxt[i] = 1'b0;
                else if (p == 2) nxt[i] = 1'b1;
            end
        end
        return nxt;
    endfunction

    task automatic modelEval();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mq[k] = rstv[k];
                me[k] = 1'b0;
                mc[k] = 0;
            end else if (clk) begin
                mq[k] = rule(mq[k], inS(k), inR(k), pol[k], wid[k]);
                if ((inS(k) & inR(k)) != 4'd0) me[k] = 1'b1;
            end
        end
    endtask

    task automatic countEdge();
        for (int k = 0; k < 4; k++) begin
            if (!rst && ((inS(k) & inR(k)) != 4'd0) && mc[k] < 255) mc[k] = mc[k] + 1;
        end
    endtask

    task automatic checkOutput(string tag, logic [7:0] obs, logic [7:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obsQ(int k);
        case (k)
            0: return {3'b000, qA};
            1: return {3'b000, qB};
            2: return {3'b000, qC};
            default: return qD;
        endcase
    endfunction

    function automatic logic [3:0] obsQb(int k);
        case (k)
            0: return {3'b000, qbA};
            1: return {3'b000, qbB};
            2: return {3'b000, qbC};
            default: return qbD;
        endcase
    endfunction

    function automatic logic [3:0] obsInv(int k);
        case (k)
            0: return {3'b000, invA};
            1: return {3'b000, invB};
            2: return {3'b000, invC};
            default: return invD;
        endcase
    endfunction

    function automatic logic obsErr(int k);
        case (k)
            0: return errA;
            1: return errB;
            2: return errC;
            default: return errD;
        endcase
    endfunction

`ifdef SR_LATCH_ERR_CNT_EN
    function automatic logic [7:0] obsCnt(int k);
        case (k)
            0: return cntA;
            1: return cntB;
            2: return cntC;
            default: return cntD;
        endcase
    endfunction
`endif

    task automatic checkAll();
        logic [3:0] expInv;
        for (int k = 0; k < 4; k++) begin
            expInv = clk ? (inS(k) & inR(k)) : 4'd0;
            checkOutput($sformatf("q[%0d]", k), {4'd0, obsQ(k)}, {4'd0, mq[k]});
            checkOutput($sformatf("qbar[%0d]", k), {4'd0, obsQb(k)}, {4'd0, ~mq[k] & widthMask(k)});
            checkOutput($sformatf("invalid[%0d]", k), {4'd0, obsInv(k)}, {4'd0, expInv});
            checkOutput($sformatf("err_sticky[%0d]", k), {7'd0, obsErr(k)}, {7'd0, me[k]});
`ifdef SR_LATCH_ERR_CNT_EN
            checkOutput($sformatf("err_cnt[%0d]", k), obsCnt(k), 8'(mc[k]));
`endif
        end
    endtask

    // Wait for an edge, account for it in the model, then drive new inputs and check
    task automatic applyStimulus(input bit rise, input logic nRst, input logic ns1, input logic nr1,
                                 input logic [3:0] ns4, input logic [3:0] nr4);
        if (rise) begin
            @(posedge clk);
        end else begin
            @(negedge clk);
            countEdge();
        end
        modelEval();
        #1;
        rst = nRst; s1 = ns1; r1 = nr1; s4 = ns4; r4 = nr4;
        modelEval();
        #1;
        checkAll();
    endtask

    // Second input change inside the same clock phase
    task automatic midStimulus(input logic ns1, input logic nr1);
        #2;
        s1 = ns1; r1 = nr1;
        modelEval();
        #1;
        checkAll();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mq[k] = 4'd0; me[k] = 1'b0; mc[k] = 0;
        end
        modelEval();
        #1;
        checkAll();

        // Reset dominates a toggling gate with s held high
        for (int i = 0; i < 4; i++) applyStimulus(i[0] == 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        checkOutput("rst_q", {7'd0, qA}, 8'd0);
        checkOutput("rst_qbar", {7'd0, qbA}, 8'd1);
        checkOutput("rst_qD", {4'd0, qD}, 8'h0A);

        // Set while open, closed phase ignores reset request, reopen clears
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        checkOutput("set_open", {7'd0, qA}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        checkOutput("hold_closed", {7'd0, qA}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        checkOutput("clr_open", {7'd0, qA}, 8'd0);
        checkOutput("clr_qbar", {7'd0, qbA}, 8'd1);

        // Transparency: s pulse while open, r pulses while closed
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        midStimulus(1'b0, 1'b0);
        checkOutput("transp_hold", {7'd0, qA}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        midStimulus(1'b0, 1'b0);
        midStimulus(1'b0, 1'b1);
        checkOutput("closed_r_pulse", {7'd0, qA}, 8'd1);

        // Invalid input from q=1 under each policy
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        midStimulus(1'b1, 1'b1);
        checkOutput("pol0_q", {7'd0, qA}, 8'd1);
        checkOutput("pol1_q", {7'd0, qB}, 8'd0);
        checkOutput("pol2_q", {7'd0, qC}, 8'd1);
        checkOutput("pol1_qbar", {7'd0, qbB}, 8'd1);
        checkOutput("inv_flag", {5'd0, invA, invB, invC}, 8'h07);
        checkOutput("err_set", {5'd0, errA, errB, errC}, 8'h07);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        checkOutput("err_stays", {5'd0, errA, errB, errC}, 8'h07);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("err_cleared", {5'd0, errA, errB, errC}, 8'h00);

        // 4-bit bank from its reset pattern
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000);
        checkOutput("w4_q", {4'd0, qD}, 8'h03);
        checkOutput("w4_inv", {4'd0, invD}, 8'h00);

        // Error counter: three edges, reset, then saturation
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        end
`ifdef SR_LATCH_ERR_CNT_EN
        checkOutput("cnt_three", cntA, 8'd3);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
`ifdef SR_LATCH_ERR_CNT_EN
        checkOutput("cnt_rst", cntA, 8'd0);
`endif
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
        end
`ifdef SR_LATCH_ERR_CNT_EN
        checkOutput("cnt_sat", cntA, 8'd255);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            applyStimulus(i[0] == 1'b0, ($urandom_range(15) == 0), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
